// File: rtl/flush_sequencer_pkg.sv
// flush_sequencer shared types and defaults.
// FSM state encoding, channel limit and default fence channel masks.
package flush_sequencer_pkg;

   localparam int unsigned MAX_FLUSH_CHANS = 8;

   localparam logic [MAX_FLUSH_CHANS-1:0] FENCE_CHAN_MASK  = 8'h01;
   localparam logic [MAX_FLUSH_CHANS-1:0] FENCEI_CHAN_MASK = 8'h03;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } flush_seq_state_e;

endpackage

// File: rtl/flush_sequencer_if.sv
// Cache flush request/acknowledge bundle, one bit per channel.
// The sequencer is the master; the cache subsystems are the slave side.
interface flush_sequencer_if #(
   parameter int unsigned NrChans = 2
);
   import flush_sequencer_pkg::*;

   logic [NrChans-1:0] flush_req;
   logic [NrChans-1:0] flush_ack;

   modport master (
      output flush_req,
      input  flush_ack
   );

   modport slave (
      input  flush_req,
      output flush_ack
   );

endinterface

// File: rtl/flush_chan_tracker.sv
// One cache flush channel: pending bit that doubles as the registered request.
// An ack clears the bit before a same-cycle set is merged in.
module flush_chan_tracker (
   input  logic clk_i,
   input  logic rst_i,
   input  logic set_i,
   input  logic ack_i,
   input  logic kill_i,
   output logic req_o
);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_o <= 1'b0;
      end else if (kill_i) begin
         req_o <= 1'b0;
      end else begin
         req_o <= (req_o & ~ack_i) | set_i;
      end
   end

endmodule

// File: rtl/flush_sequencer.sv
// Pipeline flush strobe decode plus multi-channel cache flush sequencer.
// Optional watchdog enabled by defining FLUSH_SEQ_TIMEOUT_EN.
module flush_sequencer
   import flush_sequencer_pkg::*;
#(
   parameter int unsigned                 NrChans       = 2,
   parameter logic [MAX_FLUSH_CHANS-1:0]  FenceMask     = FENCE_CHAN_MASK,
   parameter logic [MAX_FLUSH_CHANS-1:0]  FenceIMask    = FENCEI_CHAN_MASK,
   parameter int unsigned                 TimeoutCycles = 4096
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic mispredict_i,
   input  logic fence_i,
   input  logic fence_i_i,
   input  logic sfence_vma_i,
   input  logic flush_csr_i,
   input  logic flush_commit_i,
   input  logic ex_valid_i,
   input  logic eret_i,
   input  logic set_debug_pc_i,
   input  logic halt_csr_i,
   output logic set_pc_commit_o,
   output logic flush_if_o,
   output logic flush_unissued_instr_o,
   output logic flush_id_o,
   output logic flush_ex_o,
   output logic flush_bp_o,
   output logic flush_icache_o,
   output logic flush_tlb_o,
   flush_sequencer_if.master fl,
   output logic halt_o,
   output logic busy_o,
   output logic timeout_o
);

   localparam logic [NrChans-1:0] FMask  = FenceMask[NrChans-1:0];
   localparam logic [NrChans-1:0] FIMask = FenceIMask[NrChans-1:0];

   flush_seq_state_e   state_q, state_d;
   logic [NrChans-1:0] pend_q;
   logic [NrChans-1:0] pend_nxt;
   logic [NrChans-1:0] m;
   logic               kill;

   // Strobes are layered lowest to highest priority.
   always_comb begin
      set_pc_commit_o        = 1'b0;
      flush_if_o             = 1'b0;
      flush_unissued_instr_o = 1'b0;
      flush_id_o             = 1'b0;
      flush_ex_o             = 1'b0;
      flush_bp_o             = 1'b0;
      flush_icache_o         = 1'b0;
      flush_tlb_o            = 1'b0;
      if (mispredict_i) begin
         flush_if_o             = 1'b1;
         flush_unissued_instr_o = 1'b1;
      end
      if (fence_i | fence_i_i | sfence_vma_i |
          flush_csr_i | flush_commit_i) begin
         set_pc_commit_o        = 1'b1;
         flush_if_o             = 1'b1;
         flush_unissued_instr_o = 1'b1;
         flush_id_o             = 1'b1;
         flush_ex_o             = 1'b1;
      end
      if (fence_i_i) begin
         flush_icache_o = 1'b1;
      end
      if (sfence_vma_i) begin
         flush_tlb_o = 1'b1;
      end
      if (ex_valid_i | eret_i | set_debug_pc_i) begin
         set_pc_commit_o        = 1'b0;
         flush_if_o             = 1'b1;
         flush_unissued_instr_o = 1'b1;
         flush_id_o             = 1'b1;
         flush_ex_o             = 1'b1;
         flush_bp_o             = 1'b1;
      end
   end

   assign m = (fence_i   ? FMask  : '0) |
              (fence_i_i ? FIMask : '0);

   assign pend_nxt = (pend_q & ~fl.flush_ack) | m;

   for (genvar k = 0; k < NrChans; k++) begin : g_chan
      flush_chan_tracker u_trk (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .set_i  (m[k]),
         .ack_i  (fl.flush_ack[k]),
         .kill_i (kill),
         .req_o  (pend_q[k])
      );
   end

   assign fl.flush_req = pend_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (|m) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (kill || !(|pend_nxt)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = (state_q == BUSY);
   assign halt_o = halt_csr_i | busy_o;

`ifdef FLUSH_SEQ_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] TMax = CntW'(TimeoutCycles);

   logic [CntW-1:0] cnt_q;
   logic            to_q;

   assign kill = busy_o && (cnt_q == TMax);

   // Counter rests at zero in IDLE, so it starts from zero on entering BUSY.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (!busy_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         to_q <= 1'b0;
      end else if (clr_i) begin
         to_q <= 1'b0;
      end else if (kill) begin
         to_q <= 1'b1;
      end
   end

   assign timeout_o = to_q;
`else
   logic unused_clr;

   assign unused_clr = clr_i;
   assign kill       = 1'b0;
   assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_flush_sequencer.sv
// Directed bench for flush_sequencer: strobe decode, channel handshake,
// merge, reset abort and (when FLUSH_SEQ_TIMEOUT_EN is defined) watchdog.
module tb_flush_sequencer;

   logic clk = 1'b0;
   logic rst;
   logic clr;
   logic mispredict, fence, fencei, sfence, fcsr, fcommit;
   logic exv, eret, dbg, halt_csr;

   logic set_pc, f_if, f_un, f_id, f_ex, f_bp, f_ic, f_tlb;
   logic halt, busy, tout;

   logic d2_set_pc, d2_if, d2_un, d2_id, d2_ex, d2_bp, d2_ic, d2_tlb;
   logic d2_halt, d2_busy, d2_tout;

   int nchk  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   flush_sequencer_if #(.NrChans(2)) fif ();
   flush_sequencer_if #(.NrChans(3)) fif2 ();

   flush_sequencer #(
      .NrChans       (2),
      .TimeoutCycles (16)
   ) u_dut (
      .clk_i                  (clk),
      .rst_i                  (rst),
      .clr_i                  (clr),
      .mispredict_i           (mispredict),
      .fence_i                (fence),
      .fence_i_i              (fencei),
      .sfence_vma_i           (sfence),
      .flush_csr_i            (fcsr),
      .flush_commit_i         (fcommit),
      .ex_valid_i             (exv),
      .eret_i                 (eret),
      .set_debug_pc_i         (dbg),
      .halt_csr_i             (halt_csr),
      .set_pc_commit_o        (set_pc),
      .flush_if_o             (f_if),
      .flush_unissued_instr_o (f_un),
      .flush_id_o             (f_id),
      .flush_ex_o             (f_ex),
      .flush_bp_o             (f_bp),
      .flush_icache_o         (f_ic),
      .flush_tlb_o            (f_tlb),
      .fl                     (fif),
      .halt_o                 (halt),
      .busy_o                 (busy),
      .timeout_o              (tout)
   );

   flush_sequencer #(
      .NrChans   (3),
      .FenceMask (8'h00)
   ) u_dut2 (
      .clk_i                  (clk),
      .rst_i                  (rst),
      .clr_i                  (clr),
      .mispredict_i           (mispredict),
      .fence_i                (fence),
      .fence_i_i              (1'b0),
      .sfence_vma_i           (sfence),
      .flush_csr_i            (fcsr),
      .flush_commit_i         (fcommit),
      .ex_valid_i             (exv),
      .eret_i                 (eret),
      .set_debug_pc_i         (dbg),
      .halt_csr_i             (halt_csr),
      .set_pc_commit_o        (d2_set_pc),
      .flush_if_o             (d2_if),
      .flush_unissued_instr_o (d2_un),
      .flush_id_o             (d2_id),
      .flush_ex_o             (d2_ex),
      .flush_bp_o             (d2_bp),
      .flush_icache_o         (d2_ic),
      .flush_tlb_o            (d2_tlb),
      .fl                     (fif2),
      .halt_o                 (d2_halt),
      .busy_o                 (d2_busy),
      .timeout_o              (d2_tout)
   );

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0;
      mispredict = 1'b0; fence = 1'b0; fencei = 1'b0; sfence = 1'b0;
      fcsr = 1'b0; fcommit = 1'b0; exv = 1'b0; eret = 1'b0; dbg = 1'b0;
      halt_csr = 1'b0;
      fif.flush_ack = '0;
      fif2.flush_ack = '0;

      // reset state
      mid();
      chk("rst_req", 8'(fif.flush_req), 8'h0);
      chk("rst_busy", 8'(busy), 8'h0);
      chk("rst_tout", 8'(tout), 8'h0);
      chk("rst_strobes", {set_pc, f_if, f_un, f_id, f_ex, f_bp, f_ic, f_tlb}, 8'h00);
      chk("rst_halt0", 8'(halt), 8'h0);
      halt_csr = 1'b1;
      #1;
      chk("rst_halt1", 8'(halt), 8'h1);
      halt_csr = 1'b0;
      cyc();
      rst = 1'b0;

      // mispredict alone
      cyc();
      mispredict = 1'b1;
      mid();
      chk("mis_strobes", {set_pc, f_if, f_un, f_id, f_ex, f_bp, f_ic, f_tlb}, 8'b0110_0000);
      cyc();
      mispredict = 1'b0;
      mid();
      chk("mis_noreq", 8'(fif.flush_req), 8'h0);
      chk("mis_nobusy", 8'(busy), 8'h0);

      // fence.i, two channels, staggered acks
      cyc();
      fencei = 1'b1;
      mid();
      chk("fi_strobes", {set_pc, f_if, f_un, f_id, f_ex, f_bp, f_ic, f_tlb}, 8'b1111_1010);
      chk("fi_req_t0", 8'(fif.flush_req), 8'h0);
      cyc();
      fencei = 1'b0;
      mid();
      chk("fi_req_t1", 8'(fif.flush_req), 8'h3);
      chk("fi_busy_t1", 8'(busy), 8'h1);
      chk("fi_halt_t1", 8'(halt), 8'h1);
      cyc();
      cyc();
      fif.flush_ack = 2'b01;
      mid();
      chk("fi_req_t3", 8'(fif.flush_req), 8'h3);
      cyc();
      fif.flush_ack = 2'b00;
      mid();
      chk("fi_req_t4", 8'(fif.flush_req), 8'h2);
      cyc();
      fif.flush_ack = 2'b01;
      cyc();
      fif.flush_ack = 2'b00;
      mid();
      chk("fi_stray_ack", 8'(fif.flush_req), 8'h2);
      chk("fi_busy_t6", 8'(busy), 8'h1);
      cyc();
      fif.flush_ack = 2'b10;
      mid();
      chk("fi_busy_t7", 8'(busy), 8'h1);
      cyc();
      fif.flush_ack = 2'b00;
      mid();
      chk("fi_busy_t8", 8'(busy), 8'h0);
      chk("fi_halt_t8", 8'(halt), 8'h0);
      chk("fi_req_t8", 8'(fif.flush_req), 8'h0);

      // fence with exception, plus zero-mask instance
      cyc();
      fence = 1'b1;
      exv = 1'b1;
      mid();
      chk("fx_strobes", {set_pc, f_if, f_un, f_id, f_ex, f_bp, f_ic, f_tlb}, 8'b0111_1100);
      chk("d2_strobes", {d2_set_pc, d2_if, d2_id, d2_bp}, 8'b0000_0111);
      cyc();
      fence = 1'b0;
      exv = 1'b0;
      fif.flush_ack = 2'b01;
      mid();
      chk("fx_req", 8'(fif.flush_req), 8'h1);
      chk("fx_busy", 8'(busy), 8'h1);
      chk("d2_busy", 8'(d2_busy), 8'h0);
      chk("d2_req", 8'(fif2.flush_req), 8'h0);
      cyc();
      fif.flush_ack = 2'b00;
      mid();
      chk("fx_min_busy", 8'(busy), 8'h0);
      chk("fx_req_done", 8'(fif.flush_req), 8'h0);

      // new fence merged while busy, ack applied first
      cyc();
      fencei = 1'b1;
      cyc();
      fencei = 1'b0;
      fence = 1'b1;
      fif.flush_ack = 2'b11;
      mid();
      chk("mg_strobe", 8'(set_pc), 8'h1);
      cyc();
      fence = 1'b0;
      fif.flush_ack = 2'b00;
      mid();
      chk("mg_req", 8'(fif.flush_req), 8'h1);
      chk("mg_busy", 8'(busy), 8'h1);
      cyc();
      fif.flush_ack = 2'b01;
      cyc();
      fif.flush_ack = 2'b00;
      mid();
      chk("mg_done", 8'(busy), 8'h0);

      // ack in idle, sfence.vma decode
      cyc();
      fif.flush_ack = 2'b11;
      sfence = 1'b1;
      mid();
      chk("sf_strobes", {set_pc, f_if, f_un, f_id, f_ex, f_bp, f_ic, f_tlb}, 8'b1111_1001);
      cyc();
      fif.flush_ack = 2'b00;
      sfence = 1'b0;
      mid();
      chk("idle_ack_req", 8'(fif.flush_req), 8'h0);
      chk("idle_ack_busy", 8'(busy), 8'h0);

      // asynchronous reset mid-flush
      cyc();
      fencei = 1'b1;
      cyc();
      fencei = 1'b0;
      mid();
      chk("ar_busy_pre", 8'(busy), 8'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_req", 8'(fif.flush_req), 8'h0);
      chk("ar_busy", 8'(busy), 8'h0);
      cyc();
      rst = 1'b0;
      fif.flush_ack = 2'b11;
      cyc();
      fif.flush_ack = 2'b00;
      mid();
      chk("ar_late_ack", {fif.flush_req, busy}, 8'h0);

`ifdef FLUSH_SEQ_TIMEOUT_EN
      // watchdog with no acks
      cyc();
      fence = 1'b1;
      cyc();
      fence = 1'b0;
      mid();
      chk("to_rise", 8'(busy), 8'h1);
      repeat (16) cyc();
      mid();
      chk("to_last_busy", 8'(busy), 8'h1);
      chk("to_not_yet", 8'(tout), 8'h0);
      cyc();
      mid();
      chk("to_fall", 8'(busy), 8'h0);
      chk("to_req", 8'(fif.flush_req), 8'h0);
      chk("to_set", 8'(tout), 8'h1);
      repeat (3) cyc();
      mid();
      chk("to_sticky", 8'(tout), 8'h1);
      cyc();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      mid();
      chk("to_clr", 8'(tout), 8'h0);
`else
      chk("to_tied", 8'(tout), 8'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
